// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative 32-bit MULT/MULTU/DIV/DIVU plus MTHI/MTLO/MFHI/MFLO.
// One result bit per cycle; busy stalls the issuing stage until the FIX cycle writes HI/LO.
//
//   state  | meaning
//   IDLE   | waiting for an issue; MT*/MF* handled here
//   MUL    | shift-add multiply, one multiplier bit per cycle
//   DIV    | restoring divide, one quotient bit per cycle
//   FIX    | sign correction and HI/LO write
module hi_lo_muldiv_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic        LO_write_enable,
  input  logic        HI_write_enable,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_result
);

  localparam logic [4:0] OP_MTLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_zero;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_idle;
  logic        w_accept;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_signed;
  logic        w_div_op;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_qbit;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_idle   = (r_state == S_IDLE);
  // MULT/MULTU/DIV/DIVU share the 100xx prefix; bit 1 selects divide, bit 0 unsigned.
  assign w_accept = start && w_idle && (alu_control[4:2] == 3'b100)
                    && LO_write_enable && HI_write_enable;
  assign w_mthi   = start && w_idle && (alu_control == OP_MTHI) && HI_write_enable;
  assign w_mtlo   = start && w_idle && (alu_control == OP_MTLO) && LO_write_enable;
  assign w_div_op = alu_control[1];
  assign w_signed = ~alu_control[0];
  assign w_abs_a  = (w_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign w_abs_b  = (w_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);

  // Remainder stays below the divisor, so the shifted value never exceeds 33 bits.
  assign w_shift = {r_rem, r_acc[31]};
  assign w_diff  = w_shift - {2'b00, r_b};
  assign w_qbit  = ~w_diff[33];

  assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_div_zero ? 32'hFFFF_FFFF
                : (r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0]);
  assign w_rem  = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_div_op ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == 6'd31) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 6'd0;
      r_b        <= 32'd0;
      r_acc      <= 64'd0;
      r_rem      <= 33'd0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt      <= 6'd0;
            r_b        <= w_abs_b;
            r_acc      <= {32'd0, w_abs_a};
            r_rem      <= 33'd0;
            r_is_div   <= w_div_op;
            r_neg_q    <= w_signed && (op_a[31] ^ op_b[31]);
            r_neg_r    <= w_signed && w_div_op && op_a[31];
            r_div_zero <= w_div_op && (op_b == 32'd0);
          end else if (w_mthi) begin
            r_hi <= op_a;
          end else if (w_mtlo) begin
            r_lo <= op_a;
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[31:1]};
          r_cnt <= r_cnt + 6'd1;
        end
        S_DIV: begin
          r_rem        <= w_qbit ? w_diff[32:0] : w_shift[32:0];
          r_acc[31:0]  <= {r_acc[30:0], w_qbit};
          r_cnt        <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = ~w_idle;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    mf_result = 32'd0;
    if (alu_control == OP_MFHI) begin
      mf_result = r_hi;
    end else if (alu_control == OP_MFLO) begin
      mf_result = r_lo;
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Scoreboard bench for hi_lo_muldiv_unit: expected HI/LO pushed at issue, popped on done.
module tb_hi_lo_muldiv_unit;

  localparam logic [4:0] MULT  = 5'b10000;
  localparam logic [4:0] MULTU = 5'b10001;
  localparam logic [4:0] DIV   = 5'b10010;
  localparam logic [4:0] DIVU  = 5'b10011;
  localparam logic [4:0] MTLO  = 5'b10101;
  localparam logic [4:0] MTHI  = 5'b10110;
  localparam logic [4:0] MFLO  = 5'b11000;
  localparam logic [4:0] MFHI  = 5'b11001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  alu_control;
  logic        LO_write_enable;
  logic        HI_write_enable;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  hi_lo_muldiv_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .alu_control     (alu_control),
    .LO_write_enable (LO_write_enable),
    .HI_write_enable (HI_write_enable),
    .op_a            (op_a),
    .op_b            (op_b),
    .busy            (busy),
    .done            (done),
    .hi              (hi),
    .lo              (lo),
    .mf_result       (mf_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result from plain integer arithmetic: {HI, LO}.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, q, m;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r   = 64'd0;
    case (op)
      MULT:  r = 64'(sa * sbv);
      MULTU: r = {32'd0, a} * {32'd0, b};
      DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sbv;
          m = sa % sbv;
          r = {m[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        check("done_without_issue", 64'(done), 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("result_hi", 64'(hi), 64'(e[63:32]));
        check("result_lo", 64'(lo), 64'(e[31:0]));
        exp_hi = e[63:32];
        exp_lo = e[31:0];
      end
    end
  end

  // All tasks are entered and left on a falling edge.
  task automatic start_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; alu_control = op; LO_write_enable = 1'b1; HI_write_enable = 1'b1;
    op_a = a; op_b = b;
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0; alu_control = 5'd0;
  endtask

  task automatic wait_md(input int exp_cycles);
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(cnt), 64'(exp_cycles));
    check("done_pulse", 64'(done), 64'd1);
  endtask

  task automatic mt(input logic [4:0] op, input logic [31:0] d);
    start = 1'b1; alu_control = op; op_a = d;
    HI_write_enable = (op == MTHI); LO_write_enable = (op == MTLO);
    @(negedge clk);
    start = 1'b0; alu_control = 5'd0; HI_write_enable = 1'b0; LO_write_enable = 1'b0;
    if (op == MTHI) exp_hi = d; else exp_lo = d;
    check("mt_busy", 64'(busy), 64'd0);
    check("mt_hi", 64'(hi), 64'(exp_hi));
    check("mt_lo", 64'(lo), 64'(exp_lo));
  endtask

  task automatic mf_check();
    alu_control = MFHI; #1;
    check("mfhi", 64'(mf_result), 64'(exp_hi));
    alu_control = MFLO; #1;
    check("mflo", 64'(mf_result), 64'(exp_lo));
    alu_control = 5'd0;
  endtask

  task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start_md(op, a, b);
    wait_md(33);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops[4];
    logic [4:0]  op;
    logic [31:0] a, b;
    ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU;

    reset_n = 1'b0; start = 1'b0; alu_control = MFHI;
    LO_write_enable = 1'b0; HI_write_enable = 1'b0; op_a = 32'd0; op_b = 32'd0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mf", 64'(mf_result), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1; alu_control = 5'd0;
    @(negedge clk);

    run_md(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0000_0000_0001);
    run_md(MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    run_md(DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_md(DIVU, 32'd7, 32'd2);
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);
    run_md(DIVU, 32'h0000_1234, 32'd0);
    check("divu_zero_hi", 64'(hi), 64'h0000_0000_0000_1234);
    check("divu_zero_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    check("div_ovf_hi", 64'(hi), 64'd0);
    run_md(DIV, 32'hFFFF_FFF9, 32'd0);
    check("div_zero_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFF9);
    run_md(MULT, 32'h8000_0000, 32'h8000_0000);

    mt(MTHI, 32'hDEAD_BEEF);
    alu_control = MFHI; #1;
    check("mfhi_after_mthi", 64'(mf_result), 64'h0000_0000_DEAD_BEEF);
    alu_control = MULT; #1;
    check("mf_other_code", 64'(mf_result), 64'd0);
    alu_control = 5'd0;
    mt(MTLO, 32'h1357_9BDF);
    mf_check();

    // No-op code and a mult missing a write enable must both be ignored.
    start = 1'b1; alu_control = 5'b00111; LO_write_enable = 1'b1; HI_write_enable = 1'b1;
    @(negedge clk);
    alu_control = MULT; HI_write_enable = 1'b0;
    @(negedge clk);
    start = 1'b0; alu_control = 5'd0; LO_write_enable = 1'b0;
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_hi", 64'(hi), 64'(exp_hi));
    check("noop_lo", 64'(lo), 64'(exp_lo));

    // MTLO and a second MULTU issued while a DIV is busy are ignored.
    start_md(DIV, 32'd100, 32'd7);
    start = 1'b1; alu_control = MTLO; LO_write_enable = 1'b1; op_a = 32'd1;
    @(negedge clk);
    start = 1'b0; alu_control = MFLO; LO_write_enable = 1'b0; #1;
    check("busy_mflo_preop", 64'(mf_result), 64'(exp_lo));
    check("busy_lo_unchanged", 64'(lo), 64'(exp_lo));
    start = 1'b1; alu_control = MULTU; LO_write_enable = 1'b1; HI_write_enable = 1'b1;
    op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0; alu_control = 5'd0; LO_write_enable = 1'b0; HI_write_enable = 1'b0;
    wait_md(31);
    check("mtlo_ignored_lo", 64'(lo), 64'd14);
    repeat (3) @(negedge clk);
    check("no_second_op", 64'(busy), 64'd0);

    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_md(op, a, b);
      if ((i % 4) == 3) begin
        mt(($urandom_range(0, 1) == 0) ? MTHI : MTLO, $urandom);
        mf_check();
      end
    end

    // Asynchronous reset in the middle of a divide.
    start_md(DIV, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    check("midrst_done_later", 64'(done), 64'd0);
    reset_n = 1'b1;
    start_md(MULTU, 32'd2, 32'd3);
    wait_md(33);
    check("post_rst_lo", 64'(lo), 64'd6);
    check("post_rst_hi", 64'(hi), 64'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
